// File: rtl/dice_pkg.sv
// Shared types and constants for the dice-guess round controller.
package dice_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROLL,
    REVEAL,
    SCORE,
    OVER
  } state_e;

  localparam logic [2:0] LFSR_SEED = 3'b100;
  localparam logic [2:0] DIE_MAX   = 3'd6;
  localparam logic [6:0] SCORE_MAX = 7'd99;

  // Maximal-length 3-bit sequence 4,1,3,7,6,5,2; the all-zero state is unreachable.
  function automatic logic [2:0] lfsr_next(input logic [2:0] s);
    return {s[1:0], s[0] ^ s[2]};
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button level, followed by a
// registered one-clock rising-edge pulse (three clocks after the input rises).
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic sync_prev_q;
  logic pulse_q;

  // NOTE: flops use non-blocking assignments so each stage samples the pre-edge value of the one before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q      <= 1'b0;
      sync_q      <= 1'b0;
      sync_prev_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      meta_q      <= btn_i;
      sync_q      <= meta_q;
      sync_prev_q <= sync_q;
      pulse_q     <= sync_q & ~sync_prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/dice_round_ctrl.sv
// Round sequencer for the dice-guess game: button edges, game tick, LFSR die,
// roll/reveal/score/game-over FSM and a saturating two-digit score.
module dice_round_ctrl
  import dice_pkg::*;
#(
  parameter int TICK_DIV     = 16777216,
  parameter int REVEAL_TICKS = 4,
  parameter int SCORE_INIT   = 10,
  parameter int WIN_BONUS    = 6,
  parameter int LOSS_PENALTY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_roll,
  input  logic       btn_guess,
  output logic [2:0] die,
  output logic [2:0] guess,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic       busy,
  output logic       win,
  output logic       game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(REVEAL_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REVEAL_LAST = RW'(REVEAL_TICKS - 1);
  localparam logic [6:0]    SCORE_RST   = 7'(SCORE_INIT);

  logic          roll_edge;
  logic          guess_edge;
  logic          tick;
  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q;
  logic [RW-1:0] reveal_cnt_q, reveal_cnt_d;
  logic [2:0]    lfsr_q;
  logic [2:0]    die_q, die_d;
  logic [2:0]    guess_q, guess_d;
  logic [6:0]    score_q, score_d;
  logic          win_q, win_d;
  logic          busy_q;
  logic          game_over_q;
  logic [7:0]    score_up;
  logic [6:0]    score_win;
  logic [6:0]    score_lose;

  btn_sync_edge u_roll_sync (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (btn_roll),
    .pulse_o (roll_edge)
  );

  btn_sync_edge u_guess_sync (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (btn_guess),
    .pulse_o (guess_edge)
  );

  assign tick = (tick_cnt_q == TICK_LAST);

  assign score_up   = {1'b0, score_q} + 8'(WIN_BONUS);
  assign score_win  = (score_up > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_up[6:0];
  assign score_lose = (score_q > 7'(LOSS_PENALTY)) ? score_q - 7'(LOSS_PENALTY) : '0;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    die_d        = die_q;
    guess_d      = guess_q;
    score_d      = score_q;
    win_d        = win_q;
    reveal_cnt_d = reveal_cnt_q;
    case (state_q)
      IDLE: begin
        if (roll_edge) begin
          state_d = ROLL;
          die_d   = '0;
        end else if (guess_edge) begin
          guess_d = (guess_q == DIE_MAX) ? 3'd1 : guess_q + 3'd1;
        end
      end
      ROLL: begin
        // A tick landing on 7 is not a valid face; keep rolling until the next tick.
        if (tick && lfsr_q != 3'd7) begin
          die_d        = lfsr_q;
          reveal_cnt_d = '0;
          state_d      = REVEAL;
        end
      end
      REVEAL: begin
        if (tick) begin
          if (reveal_cnt_q == REVEAL_LAST) state_d = SCORE;
          else                             reveal_cnt_d = reveal_cnt_q + 1'b1;
        end
      end
      SCORE: begin
        if (die_q == guess_q) begin
          score_d = score_win;
          win_d   = 1'b1;
        end else begin
          score_d = score_lose;
          win_d   = 1'b0;
        end
        state_d = (score_d == '0) ? OVER : IDLE;
      end
      OVER: begin
        if (roll_edge) begin
          score_d = SCORE_RST;
          guess_d = 3'd1;
          die_d   = '0;
          win_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      lfsr_q     <= (state_q == ROLL) ? lfsr_next(lfsr_q) : lfsr_q;
    end
  end

  // busy/game_over are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      die_q        <= '0;
      guess_q      <= 3'd1;
      score_q      <= SCORE_RST;
      win_q        <= 1'b0;
      reveal_cnt_q <= '0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      die_q        <= die_d;
      guess_q      <= guess_d;
      score_q      <= score_d;
      win_q        <= win_d;
      reveal_cnt_q <= reveal_cnt_d;
      busy_q       <= state_d inside {ROLL, REVEAL, SCORE};
      game_over_q  <= (state_d == OVER);
    end
  end

  assign die        = die_q;
  assign guess      = guess_q;
  assign score_tens = bcd_tens(score_q);
  assign score_ones = bcd_ones(score_q);
  assign busy       = busy_q;
  assign win        = win_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_dice_round_ctrl.sv
// Bench for dice_round_ctrl: three instances (score start 10, 95, 1) compared every
// cycle against a game-rule model, plus table-driven and hand-timed corner cases.
module tb_dice_round_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int REVEAL_TICKS = 2;
  localparam int WIN_BONUS    = 6;
  localparam int LOSS_PENALTY = 1;
  localparam int NI           = 3;

  localparam int P_IDLE   = 0;
  localparam int P_ROLL   = 1;
  localparam int P_REVEAL = 2;
  localparam int P_SCORE  = 3;
  localparam int P_OVER   = 4;

  typedef struct packed {
    int       phase;
    int       li;
    int       die;
    int       guess;
    int       score;
    int       rt;
    bit       win;
    logic [3:0] hr;
    logic [3:0] hg;
  } mstate_t;

  typedef struct {
    int hold;
    int exp_guess;
  } gvec_t;

  logic       clk;
  logic       reset;
  logic       b_roll  [NI];
  logic       b_guess [NI];
  logic [2:0] o_die   [NI];
  logic [2:0] o_guess [NI];
  logic [3:0] o_tens  [NI];
  logic [3:0] o_ones  [NI];
  logic       o_busy  [NI];
  logic       o_win   [NI];
  logic       o_go    [NI];

  mstate_t m_st [NI];
  int      m_cyc;
  int      n_tests;
  int      n_fail;

  dice_round_ctrl #(.TICK_DIV(TICK_DIV), .REVEAL_TICKS(REVEAL_TICKS), .SCORE_INIT(10),
                    .WIN_BONUS(WIN_BONUS), .LOSS_PENALTY(LOSS_PENALTY)) u_a (
    .clk(clk), .reset(reset), .btn_roll(b_roll[0]), .btn_guess(b_guess[0]),
    .die(o_die[0]), .guess(o_guess[0]), .score_tens(o_tens[0]), .score_ones(o_ones[0]),
    .busy(o_busy[0]), .win(o_win[0]), .game_over(o_go[0])
  );

  dice_round_ctrl #(.TICK_DIV(TICK_DIV), .REVEAL_TICKS(REVEAL_TICKS), .SCORE_INIT(95),
                    .WIN_BONUS(WIN_BONUS), .LOSS_PENALTY(LOSS_PENALTY)) u_b (
    .clk(clk), .reset(reset), .btn_roll(b_roll[1]), .btn_guess(b_guess[1]),
    .die(o_die[1]), .guess(o_guess[1]), .score_tens(o_tens[1]), .score_ones(o_ones[1]),
    .busy(o_busy[1]), .win(o_win[1]), .game_over(o_go[1])
  );

  dice_round_ctrl #(.TICK_DIV(TICK_DIV), .REVEAL_TICKS(REVEAL_TICKS), .SCORE_INIT(1),
                    .WIN_BONUS(WIN_BONUS), .LOSS_PENALTY(LOSS_PENALTY)) u_c (
    .clk(clk), .reset(reset), .btn_roll(b_roll[2]), .btn_guess(b_guess[2]),
    .die(o_die[2]), .guess(o_guess[2]), .score_tens(o_tens[2]), .score_ones(o_ones[2]),
    .busy(o_busy[2]), .win(o_win[2]), .game_over(o_go[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int init_of(input int k);
    case (k)
      0:       return 10;
      1:       return 95;
      default: return 1;
    endcase
  endfunction

  // Die sequence starting from the seed, indexed by steps taken.
  function automatic int lfsr_at(input int i);
    case (i % 7)
      0:       return 4;
      1:       return 1;
      2:       return 3;
      3:       return 7;
      4:       return 6;
      5:       return 5;
      default: return 2;
    endcase
  endfunction

  function automatic mstate_t reset_state(input int k);
    mstate_t s;
    s.phase = P_IDLE; s.li = 0; s.die = 0; s.guess = 1;
    s.score = init_of(k); s.rt = 0; s.win = 1'b0; s.hr = '0; s.hg = '0;
    return s;
  endfunction

  // A button press reaches the game three clocks after the level is first sampled high.
  function automatic mstate_t next_state(input mstate_t s, input bit br, input bit bg,
                                         input bit tick, input int init);
    mstate_t n;
    bit      r_edge;
    bit      g_edge;
    int      lv;
    n      = s;
    r_edge = s.hr[2] & ~s.hr[3];
    g_edge = s.hg[2] & ~s.hg[3];
    lv     = lfsr_at(s.li);
    n.hr   = {s.hr[2:0], br};
    n.hg   = {s.hg[2:0], bg};
    if (s.phase == P_ROLL) n.li = (s.li + 1) % 7;
    case (s.phase)
      P_IDLE: begin
        if (r_edge) begin
          n.phase = P_ROLL; n.die = 0;
        end else if (g_edge) begin
          n.guess = (s.guess == 6) ? 1 : s.guess + 1;
        end
      end
      P_ROLL: if (tick && lv != 7) begin
        n.die = lv; n.phase = P_REVEAL; n.rt = 0;
      end
      P_REVEAL: if (tick) begin
        n.rt = s.rt + 1;
        if (n.rt == REVEAL_TICKS) n.phase = P_SCORE;
      end
      P_SCORE: begin
        if (s.die == s.guess) begin
          n.score = (s.score + WIN_BONUS > 99) ? 99 : s.score + WIN_BONUS; n.win = 1'b1;
        end else begin
          n.score = (s.score - LOSS_PENALTY < 0) ? 0 : s.score - LOSS_PENALTY; n.win = 1'b0;
        end
        n.phase = (n.score == 0) ? P_OVER : P_IDLE;
      end
      default: if (r_edge) begin
        n.score = init; n.guess = 1; n.die = 0; n.win = 1'b0; n.phase = P_IDLE;
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cyc <= 0;
      for (int k = 0; k < NI; k++) m_st[k] <= reset_state(k);
    end else begin
      for (int k = 0; k < NI; k++)
        m_st[k] <= next_state(m_st[k], b_roll[k], b_guess[k],
                              (m_cyc % TICK_DIV) == TICK_DIV - 1, init_of(k));
      m_cyc <= m_cyc + 1;
    end
  end

  // Steps from the edge that consumes a roll to the first tick edge after it.
  function automatic int first_steps(input int c0);
    for (int j = c0 + 1; j <= c0 + TICK_DIV; j++)
      if (j % TICK_DIV == TICK_DIV - 1) return j - c0 - 1;
    return 0;
  endfunction

  // Die value latched for a roll consumed at edge index c0 with the LFSR at index li.
  function automatic int predict(input int li, input int c0);
    for (int j = c0 + 1; j < c0 + 40; j++)
      if (j % TICK_DIV == TICK_DIV - 1 && lfsr_at(li + j - c0 - 1) != 7)
        return lfsr_at(li + j - c0 - 1);
    return 0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic compare_model(input int k);
    mstate_t     s;
    logic [16:0] got;
    logic [16:0] exp;
    s   = m_st[k];
    got = {o_die[k], o_guess[k], o_tens[k], o_ones[k], o_busy[k], o_win[k], o_go[k]};
    exp = {3'(s.die), 3'(s.guess), 4'(s.score / 10), 4'(s.score % 10),
           (s.phase == P_ROLL || s.phase == P_REVEAL || s.phase == P_SCORE),
           s.win, (s.phase == P_OVER)};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL model_inst%0d t=%0t: got %h expected %h", k, $time, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (reset) for (int k = 0; k < NI; k++) compare_model(k);
    end
  endtask

  task automatic press(input int k, input bit is_roll, input int hold);
    if (is_roll) b_roll[k] = 1'b1; else b_guess[k] = 1'b1;
    cyc(hold);
    if (is_roll) b_roll[k] = 1'b0; else b_guess[k] = 1'b0;
  endtask

  task automatic align(input int r);
    for (int i = 0; i < TICK_DIV && (m_cyc % TICK_DIV) != r; i++) cyc(1);
  endtask

  task automatic wait_round(input int k);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (m_st[k].phase == P_IDLE || m_st[k].phase == P_OVER) done = 1'b1;
      else cyc(1);
    end
    check($sformatf("round_end_inst%0d", k), done, 1);
  endtask

  // Plays one round from IDLE with the guess set to (match) or away from the predicted die.
  task automatic do_round(input int k, input bit match);
    int r, tgt, want, n;
    r    = $urandom_range(0, TICK_DIV - 1);
    tgt  = predict(m_st[k].li, r + 3);
    want = match ? tgt : (tgt % 6) + 1;
    n    = (want - m_st[k].guess + 6) % 6;
    for (int i = 0; i < n; i++) begin
      press(k, 0, 1);
      cyc(2);
    end
    cyc(4);
    align(r);
    press(k, 1, 1);
    cyc(3);
    check($sformatf("busy_in_roll_inst%0d", k), o_busy[k], 1);
    wait_round(k);
    cyc(1);
    check($sformatf("die_inst%0d", k), o_die[k], tgt);
    check($sformatf("win_inst%0d", k), o_win[k], match);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    gvec_t gtab [7];
    int    found, r7, li, s, exp_die, g_before;

    gtab[0] = '{1, 2};  gtab[1] = '{1, 3};  gtab[2] = '{2, 4};  gtab[3] = '{1, 5};
    gtab[4] = '{3, 6};  gtab[5] = '{1, 1};  gtab[6] = '{20, 2};

    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    for (int k = 0; k < NI; k++) begin
      b_roll[k]  = 1'b0;
      b_guess[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset values
    check("rst_die",   o_die[0],   0);
    check("rst_guess", o_guess[0], 1);
    check("rst_tens",  o_tens[0],  1);
    check("rst_ones",  o_ones[0],  0);
    check("rst_busy",  o_busy[0],  0);
    check("rst_go",    o_go[0],    0);
    check("rst_win",   o_win[0],   0);
    check("rst_b_tens", o_tens[1], 9);
    check("rst_b_ones", o_ones[1], 5);
    check("rst_c_ones", o_ones[2], 1);
    cyc(2);

    // Guess stepping, wrap and a long hold giving one step
    for (int i = 0; i < 7; i++) begin
      press(0, 0, gtab[i].hold);
      cyc(5);
      check($sformatf("guess_step%0d", i), o_guess[0], gtab[i].exp_guess);
    end

    // Matching rounds saturate at 99
    do_round(1, 1);
    check("sat1_tens", o_tens[1], 9);
    check("sat1_ones", o_ones[1], 9);
    do_round(1, 1);
    check("sat2_tens", o_tens[1], 9);
    check("sat2_ones", o_ones[1], 9);

    // Losing to zero, game over, restart
    do_round(2, 0);
    check("over_go",   o_go[2],   1);
    check("over_tens", o_tens[2], 0);
    check("over_ones", o_ones[2], 0);
    check("over_busy", o_busy[2], 0);
    g_before = m_st[2].guess;
    press(2, 0, 1);
    cyc(5);
    check("over_guess_ignored", o_guess[2], g_before);
    press(2, 1, 1);
    cyc(5);
    check("restart_ones",  o_ones[2],  1);
    check("restart_tens",  o_tens[2],  0);
    check("restart_guess", o_guess[2], 1);
    check("restart_go",    o_go[2],    0);
    check("restart_die",   o_die[2],   0);

    // Tick landing on LFSR value 7
    found = 0;
    r7    = 0;
    for (int a = 0; a < 16 && found == 0; a++) begin
      for (int rr = 0; rr < TICK_DIV; rr++)
        if (found == 0 && lfsr_at(m_st[0].li + first_steps(rr + 3)) == 7) begin
          found = 1;
          r7    = rr;
        end
      if (found == 0) do_round(0, 1);
    end
    check("lfsr7_setup", found, 1);
    if (found != 0) begin
      li      = m_st[0].li;
      s       = first_steps(r7 + 3);
      exp_die = predict(li, r7 + 3);
      align(r7);
      press(0, 1, 1);
      cyc(3 + s + 1);
      check("lfsr7_die_blank", o_die[0],  0);
      check("lfsr7_busy",      o_busy[0], 1);
      cyc(TICK_DIV);
      check("lfsr7_die_next",  o_die[0],  exp_die);
      wait_round(0);
      cyc(2);
    end

    // Simultaneous roll and guess edges: roll wins
    g_before   = m_st[0].guess;
    b_roll[0]  = 1'b1;
    b_guess[0] = 1'b1;
    cyc(1);
    b_roll[0]  = 1'b0;
    b_guess[0] = 1'b0;
    cyc(3);
    check("both_busy",  o_busy[0],  1);
    check("both_guess", o_guess[0], g_before);

    // Asynchronous reset in the middle of REVEAL
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (m_st[0].phase == P_REVEAL) found = 1;
      else cyc(1);
    end
    check("reach_reveal", found, 1);
    cyc(3);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_die",   o_die[0],   0);
    check("mid_rst_busy",  o_busy[0],  0);
    check("mid_rst_tens",  o_tens[0],  1);
    check("mid_rst_ones",  o_ones[0],  0);
    check("mid_rst_guess", o_guess[0], 1);
    check("mid_rst_b_ones", o_ones[1], 5);
    cyc(2);
    reset = 1'b1;
    cyc(2);

    // Random button activity on all instances against the model
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < NI; k++) begin
        b_roll[k]  = ($urandom_range(0, 7) == 0);
        b_guess[k] = ($urandom_range(0, 5) == 0);
      end
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dice_round_ctrl.md
Name: dice_round_ctrl

Overview:
- Round sequencer for the dice-guess game datapath: LFSR die, player guess, two-digit score.
- Takes debounced push-buttons. Divides clk into a game tick. Runs each round: roll, reveal, score, game over.
- Presents die, guess and BCD score to the existing 7-segment display multiplexer.

Parameters:
- TICK_DIV, 16777216: clk cycles per game tick (2^24, about 0.33 s at 50 MHz).
- REVEAL_TICKS, 4: ticks the die is held in REVEAL before scoring.
- SCORE_INIT, 10: score loaded at reset and on new game (0..99).
- WIN_BONUS, 6: points added on a correct guess.
- LOSS_PENALTY, 1: points removed on a wrong guess.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_roll  in  1  roll / new-game button, asynchronous level
- btn_guess  in  1  guess-increment button, asynchronous level
- die  out  3  latched die value 1..6; 0 = blank
- guess  out  3  current guess 1..6
- score_tens  out  4  BCD tens digit of score
- score_ones  out  4  BCD ones digit of score
- busy  out  1  high in ROLL, REVEAL, SCORE
- win  out  1  result of last scored round
- game_over  out  1  high in OVER state

Behaviour:
- Reset is asserted while reset=0 and takes effect immediately, mid-round included. Reset values:
  - state IDLE, die=0, guess=1, score=SCORE_INIT, win=0, game_over=0, busy=0
  - lfsr=3'b100, tick counter=0
- Buttons: each passes a 2-flop synchronizer, then a rising-edge detector. Edge pulse lasts 1 clk, 3 clk after the input rises; holding a button gives one edge only.
- Tick: counter runs 0..TICK_DIV-1 in every state. tick=1 for the cycle the counter equals TICK_DIV-1, then the counter wraps to 0.
- LFSR: 3 bits, next = {lfsr[1:0], lfsr[0]^lfsr[2]}. Period 7 (4,1,3,7,6,5,2). Never 0. Steps every clk only in ROLL; holds in all other states.
- Score: 7-bit binary internally. BCD outputs are combinational from the score register: tens=score/10, ones=score%10.
- IDLE:
  - guess edge: guess increments; 6 wraps to 1.
  - roll edge: go to ROLL, die=0, busy=1.
  - Roll and guess edges in the same cycle: roll wins; the guess edge is discarded.
- ROLL:
  - On tick with lfsr in 1..6: die<=lfsr, go to REVEAL.
  - On tick with lfsr=7: stay in ROLL until the next tick.
  - Guess and roll edges are ignored.
- REVEAL: count REVEAL_TICKS ticks, counting from the first tick after entry, then go to SCORE. Buttons are ignored.
- SCORE (exactly 1 clk):
  - die==guess: score<=min(score+WIN_BONUS,99), win<=1.
  - Otherwise: score<=max(score-LOSS_PENALTY,0), win<=0.
  - Next state is OVER if the new score is 0, else IDLE.
  - busy drops on the cycle the state leaves SCORE.
- OVER:
  - game_over=1; die and win hold.
  - Roll edge: score=SCORE_INIT, guess=1, die=0, win=0, game_over=0, go to IDLE. The LFSR is not reseeded.
  - Guess edges are ignored.
- Outputs die, guess, win, game_over and busy are registered.

Decomposition:
- Shared package dice_pkg holds:
  - state enum (IDLE, ROLL, REVEAL, SCORE, OVER)
  - LFSR_SEED=3'b100, DIE_MAX=6, SCORE_MAX=99
- Sub-module btn_sync_edge: 2-flop synchronizer plus rising-edge pulse, same clk and reset. Instantiated twice, once per button.
- Tick divider, LFSR, FSM and score arithmetic stay in dice_round_ctrl.

Test Plan:
Bench settings: TICK_DIV=4, REVEAL_TICKS=2; bench carries a cycle-accurate LFSR model.
1. Hold reset=0 mid-sim, then release -> score_tens=1, score_ones=0, guess=1, die=0, busy=0, game_over=0; the tick period is 4 clk.
2. Six btn_guess presses in IDLE -> guess steps 2,3,4,5,6,1. A press held high for 20 clk advances guess once only.
3. Set guess to the model-predicted die (SCORE_INIT=95), press roll -> busy=1 until after REVEAL (2 ticks) and SCORE; then score=99 (tens 9, ones 9), win=1. A second matching round keeps score at 99.
4. SCORE_INIT=1, wrong guess -> score=0, game_over=1, state OVER. btn_guess is ignored; btn_roll restores score=01, guess=1, game_over=0.
5. Roll timed so the tick lands on lfsr=7 -> die stays 0 and the state stays ROLL one extra tick; die then equals the next non-7 model value.
6. Roll and guess rising edges in the same cycle in IDLE -> ROLL entered, guess unchanged. Assert reset during REVEAL -> immediate IDLE, die=0, busy=0, score=SCORE_INIT.
